// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencing for the five-stage pipeline: load-use stall, EX mispredict flush, data-memory freeze.
// Optional performance counters compiled in with HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_branch,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch,
  input  logic             ex_taken,
  input  logic             ex_predicted,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic [1:0]       redirect_sel,
`ifdef HAZARD_PERF_CNT_EN
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] branch_cnt,
`endif
  output logic             wait_err
);

  localparam int unsigned WW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(MAX_WAIT);

  typedef enum logic [1:0] {S_RUN, S_STALL, S_FLUSH, S_FREEZE} state_t;

  state_t        state_q, state_d;
  logic          id_v_q, id_v_d;
  logic          ex_v_q, ex_v_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          wait_err_q, wait_err_d;
  logic          hazard_chk;
  logic          mispredict;
  logic          load_use;
  logic          unused_id_branch;

  assign unused_id_branch = id_branch;

  // STALL and FLUSH leave a bubble in EX, so hazard detection only runs from RUN
  // or from FREEZE in the cycle mem_busy drops.
  always_comb begin
    hazard_chk = 1'b0;
    unique case (state_q)
      S_RUN, S_FREEZE:  hazard_chk = 1'b1;
      S_STALL, S_FLUSH: hazard_chk = 1'b0;
      default:          hazard_chk = 1'b0;
    endcase
    mispredict = hazard_chk & ex_v_q & ex_branch & (ex_taken != ex_predicted);
    load_use   = hazard_chk & ex_v_q & ex_mem_read & id_v_q & (ex_rd != '0) &
                 ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
  end

  always_comb begin
    state_d      = state_q;
    id_v_d       = id_v_q;
    ex_v_d       = ex_v_q;
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_hold   = 1'b0;
    redirect_sel = 2'b00;

    if (mem_busy) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      exmem_hold = 1'b1;
      state_d    = S_FREEZE;
    end else if (mispredict) begin
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      redirect_sel = ex_taken ? 2'b01 : 2'b10;
      id_v_d       = 1'b0;
      ex_v_d       = 1'b0;
      state_d      = S_FLUSH;
    end else if (load_use) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ex_v_d      = 1'b0;
      state_d     = S_STALL;
    end else begin
      id_v_d  = 1'b1;
      ex_v_d  = id_v_q;
      state_d = S_RUN;
    end

    if (reset) begin
      pc_write     = 1'b0;
      ifid_write   = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_hold   = 1'b0;
      redirect_sel = 2'b00;
    end
  end

  always_comb begin
    wait_cnt_d = '0;
    if (mem_busy) begin
      wait_cnt_d = (wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + 1'b1;
    end
    wait_err_d = wait_err_q | (wait_cnt_d == WAIT_MAX);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_RUN;
      id_v_q     <= 1'b0;
      ex_v_q     <= 1'b0;
      wait_cnt_q <= '0;
      wait_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_v_q     <= id_v_d;
      ex_v_q     <= ex_v_d;
      wait_cnt_q <= wait_cnt_d;
      wait_err_q <= wait_err_d;
    end
  end

  assign wait_err = wait_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;

  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    branch_cnt_d = branch_cnt_q;
    if (!mem_busy) begin
      if (mispredict) begin
        flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end else if (load_use) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (hazard_chk & ex_v_q & ex_branch) begin
        branch_cnt_d = branch_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      branch_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      branch_cnt_q <= branch_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;
  assign branch_cnt = branch_cnt_q;
`else
  localparam int unsigned unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each driven cycle queues its expected
// outputs, which are popped and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CW = 32;

  localparam logic [7:0] NORM = 8'b1100_0000;
  localparam logic [7:0] STL  = 8'b0001_0000;
  localparam logic [7:0] FLT  = 8'b1011_0010;
  localparam logic [7:0] FLN  = 8'b1011_0100;
  localparam logic [7:0] FRZ  = 8'b0000_1000;
  localparam logic [7:0] RST  = 8'b0011_0000;
  localparam logic [7:0] ERR  = 8'b0000_0001;

  typedef struct packed {
    logic [7:0]  outs;
    logic [31:0] st;
    logic [31:0] fl;
    logic [31:0] br;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic          id_uses_rs2 = 1'b0, id_branch = 1'b0, ex_mem_read = 1'b0;
  logic          ex_branch = 1'b0, ex_taken = 1'b0, ex_predicted = 1'b0, mem_busy = 1'b0;
  logic          pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, wait_err;
  logic [1:0]    redirect_sel;
`ifdef HAZARD_PERF_CNT_EN
  logic [CW-1:0] stall_cnt, flush_cnt, branch_cnt;
`endif

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned n_cyc    = 0;

  pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2), .id_branch(id_branch),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch(ex_branch),
    .ex_taken(ex_taken), .ex_predicted(ex_predicted), .mem_busy(mem_busy),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .exmem_hold(exmem_hold), .redirect_sel(redirect_sel),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .branch_cnt(branch_cnt),
`endif
    .wait_err(wait_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic busy,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                      input logic mr, input logic [4:0] rd,
                      input logic br, input logic tk, input logic pr,
                      input logic [7:0] eo, input int unsigned es, input int unsigned ef,
                      input int unsigned eb);
    exp_t x;
    @(posedge clk);
    #1;
    reset        = rst;
    mem_busy     = busy;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_uses_rs2  = u2;
    ex_mem_read  = mr;
    ex_rd        = rd;
    ex_branch    = br;
    ex_taken     = tk;
    ex_predicted = pr;
    x.outs = eo;
    x.st   = es;
    x.fl   = ef;
    x.br   = eb;
    exp_q.push_back(x);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val($sformatf("outs_c%0d", n_cyc),
                64'({pc_write, ifid_write, ifid_flush, idex_bubble, exmem_hold, redirect_sel, wait_err}),
                64'(e.outs));
`ifdef HAZARD_PERF_CNT_EN
      check_val($sformatf("stall_cnt_c%0d", n_cyc), 64'(stall_cnt), 64'(e.st));
      check_val($sformatf("flush_cnt_c%0d", n_cyc), 64'(flush_cnt), 64'(e.fl));
      check_val($sformatf("branch_cnt_c%0d", n_cyc), 64'(branch_cnt), 64'(e.br));
`endif
      n_cyc++;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, RST,  0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);  // first cycle out of reset
    step(0, 0, 5, 0, 0, 1, 5, 0, 0, 0, NORM, 0, 0, 0);  // EX still invalid
    step(0, 0, 5, 1, 1, 1, 5, 0, 0, 0, STL,  0, 0, 0);  // ld x5 ; add x6,x5,x1
    step(0, 0, 5, 1, 1, 1, 5, 0, 0, 0, NORM, 1, 0, 0);  // bubble in EX
    step(0, 0, 3, 7, 1, 1, 7, 0, 0, 0, STL,  1, 0, 0);  // rs2 match
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 0, 0);
    step(0, 0, 2, 7, 0, 1, 7, 0, 0, 0, NORM, 2, 0, 0);  // rs2 not read
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0, NORM, 2, 0, 0);  // x0 never hazards
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FLT,  2, 0, 0);  // taken, predicted not taken
    step(0, 0, 5, 0, 0, 1, 5, 0, 0, 0, NORM, 2, 1, 1);  // after flush: no hazard
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 1, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, NORM, 2, 1, 1);  // correctly predicted
    step(0, 0, 5, 0, 0, 1, 5, 1, 0, 1, FLN,  2, 1, 2);  // mispredict beats load-use
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 2, 2, 3);
    for (int i = 0; i < 3; i++) step(0, 1, 5, 0, 0, 1, 5, 0, 0, 0, FRZ, 2, 2, 3);
    step(0, 0, 5, 0, 0, 1, 5, 0, 0, 0, STL,  2, 2, 3);  // stall after freeze
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 3, 2, 3);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, FRZ, 3, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 3, 2, 3);  // 14 busy cycles: no error
    for (int i = 0; i < 15; i++) step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ, 3, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | ERR, 3, 2, 3);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM | ERR, 3, 2, 3);
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, FRZ | ERR,  3, 2, 3);
    step(1, 1, 5, 0, 0, 1, 5, 1, 1, 0, RST,  0, 0, 0);  // reset mid-freeze
    step(0, 0, 5, 0, 0, 1, 5, 1, 1, 0, NORM, 0, 0, 0);  // valid bits cleared
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, NORM, 0, 0, 0);
    @(negedge clk);
    #1;
    check_val("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequencing controller for the five-stage RISC-V pipeline. It decides each cycle whether the PC, IF/ID and ID/EX registers advance, stall, bubble or flush. It covers load-use hazards, branch mispredicts resolved in EX, and a multi-cycle data-memory wait. It also tracks per-stage valid bits and optionally counts hazard events.

## Interface
- `MAX_WAIT`, default 15: number of consecutive `mem_busy` cycles tolerated before `wait_err` is raised.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in ID.
- `id_uses_rs2` in 1: the ID instruction reads rs2 (R-type, S-type, B-type).
- `id_branch` in 1: the ID instruction is a branch.
- `ex_mem_read` in 1: the EX instruction is a load.
- `ex_rd` in 5: destination register of the EX instruction.
- `ex_branch` in 1: the EX instruction is a branch.
- `ex_taken` in 1: resolved branch outcome in EX.
- `ex_predicted` in 1: prediction made in ID for that branch.
- `mem_busy` in 1: data memory requests a pipeline freeze.
- `pc_write` out 1: PC register loads.
- `ifid_write` out 1: IF/ID register loads.
- `ifid_flush` out 1: IF/ID captures a bubble.
- `idex_bubble` out 1: ID/EX captures zeroed control signals.
- `exmem_hold` out 1: EX/MEM and MEM/WB hold their contents.
- `redirect_sel` out 2: PC source select.
  - 00: predicted PC.
  - 01: EX branch target.
  - 10: EX PC+4.
- `wait_err` out 1: sticky watchdog flag.
- `stall_cnt`, `flush_cnt`, `branch_cnt` out `CNT_W`: performance counters (only with the macro enabled).

## Operation
- Internal valid bits:
  - `id_v` is 1 when IF/ID holds a real instruction.
  - `ex_v` is 1 when ID/EX holds a real instruction.
  - Both bits advance with the pipeline.
  - Both clear on a flush or bubble.
- Derived conditions:
  - Mispredict: `ex_v & ex_branch & (ex_taken != ex_predicted)`.
  - Load-use: `ex_v & ex_mem_read & id_v & ex_rd != 0`, and either `ex_rd == id_rs1` or (`id_uses_rs2` and `ex_rd == id_rs2`).
- Priority, highest first:
  1. `reset`
  2. `mem_busy`
  3. mispredict
  4. load-use
  5. normal flow.
- FSM states:
  - RUN: default state.
    - `mem_busy` goes to FREEZE.
    - Mispredict goes to FLUSH.
    - Load-use goes to STALL.
    - Otherwise stays in RUN.
  - STALL: lasts exactly one cycle.
    - Goes to FREEZE if `mem_busy`, otherwise to RUN.
    - A second load-use cannot occur here, because EX holds a bubble.
  - FLUSH: lasts exactly one cycle; `id_v` is 0, so no load-use check is made.
    - Goes to FREEZE if `mem_busy`, otherwise to RUN.
  - FREEZE: entered while `mem_busy` = 1.
    - On `mem_busy` falling, returns to RUN and re-evaluates hazards that cycle.
- Outputs per condition:
  - Freeze: `pc_write`=0, `ifid_write`=0, `idex_bubble`=0, `exmem_hold`=1, `redirect_sel`=00.
  - Mispredict: `pc_write`=1, `ifid_flush`=1, `idex_bubble`=1, `redirect_sel`=01 if `ex_taken`, else 10.
  - Load-use: `pc_write`=0, `ifid_write`=0, `idex_bubble`=1.
  - Normal: `pc_write`=1, `ifid_write`=1, all other outputs 0.
- Simultaneous mispredict and load-use: the mispredict wins, because the load-use instruction is on the wrong path.
- Watchdog:
  - A wait counter increments each cycle `mem_busy` = 1 and clears when it is 0.
  - When the counter reaches `MAX_WAIT`, `wait_err` is set and stays set until reset.
  - The counter saturates at `MAX_WAIT`.

## Timing
- All control outputs are combinational (Mealy) from the state, the valid bits and the inputs of the same cycle.
- All state, valid bits and counters update on the rising edge of `clk`.
- While `reset` = 1, outputs are forced to:
  - `pc_write`=0, `ifid_write`=0, `ifid_flush`=1, `idex_bubble`=1, `exmem_hold`=0, `redirect_sel`=00, `wait_err`=0.
  - Counters = 0.
  - State = RUN, `id_v`=0, `ex_v`=0.
- Reset asserted mid-stall or mid-freeze aborts immediately; there is no pending redirect after release.
- Mispredict in EX at cycle t:
  - At edge t+1 the PC holds the corrected address.
  - At edge t+1 `id_v` and `ex_v` are 0.
  - Penalty is 2 cycles.
- Load-use penalty is exactly 1 bubble; forwarding from MEM resolves the data afterwards.
- FREEZE adds zero extra cycles after `mem_busy` deasserts.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: three counters are compiled in, each wrapping modulo 2^`CNT_W`.
  - `stall_cnt` increments once per load-use bubble.
  - `flush_cnt` increments once per mispredict.
  - `branch_cnt` increments once per valid branch resolved in EX.
  - Nothing is counted during FREEZE.
- Macro undefined: the counters and their ports are absent, and the control behaviour is identical.

## Test plan
- Reset then release, with a NOP stream:
  - Cycle 1: `pc_write`=1, `redirect_sel`=00.
  - `id_v` becomes 1 after the first edge.
- `ld x5`, then `add x6,x5,x1`:
  - Exactly one cycle with `pc_write`=0 and `idex_bubble`=1, then RUN.
  - `stall_cnt`=1.
- Branch with `ex_taken`=1, `ex_predicted`=0:
  - `redirect_sel`=01, `ifid_flush`=1 and `idex_bubble`=1 for one cycle.
  - The next cycle shows no hazard even if `ex_mem_read` is 1.
  - `flush_cnt`=1.
- Mispredict coinciding with a load-use on x5:
  - Only flush outputs are asserted (`redirect_sel`=10 when not taken).
  - `stall_cnt` is unchanged.
- `mem_busy` high for 3 cycles during a load-use:
  - All writes are 0 and `exmem_hold`=1 for 3 cycles.
  - The stall then executes once.
  - `wait_err` stays 0.
- `mem_busy` high for 15 cycles: `wait_err`=1 from that edge on, cleared only by `reset`.
